// File: rtl/jt7759_pkg.sv
// jt7759_pkg: shared widths and arbiter state encodings for the jt7759 ROM arbiter
package jt7759_pkg;
   localparam int JT7759_AW = 17;
   localparam int JT7759_DW = 8;
   typedef enum logic [2:0] {
      ARB_IDLE  = 3'b001,
      ARB_GUARD = 3'b010,
      ARB_WAIT  = 3'b100
   } arb_state_t;
endpackage

// File: rtl/jt7759_arb_line.sv
// jt7759_arb_line: one-byte cache line (tag, data, valid) with combinational hit
// Ports: clk, rstn (sync, active low); cs/addr requester lookup; wr/wr_addr/wr_data
// fill from the arbiter; data = cached byte (held), ok = hit for the current addr.
module jt7759_arb_line
   import jt7759_pkg::*;
#(
   parameter int AW = JT7759_AW,
   parameter int DW = JT7759_DW
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          cs,
   input  logic [AW-1:0] addr,
   input  logic          wr,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic [DW-1:0] data,
   output logic          ok
);
   logic [AW-1:0] tag;
   logic          valid;
   always_ff @(posedge clk) begin
      if (!rstn) begin
         valid <= 1'b0;
         tag   <= '0;
         data  <= '0;
      end else if (wr) begin
         valid <= 1'b1;
         tag   <= wr_addr;
         data  <= wr_data;
      end
   end
   assign ok = cs && valid && tag == addr;
endmodule

// File: rtl/jt7759_rom_arb.sv
// jt7759_rom_arb: shares one sample-ROM port between NCH cached jt7759 requesters
// Ports: clk, rstn (sync, active low); ch_cs/ch_addr/ch_data/ch_ok per channel
// (channel i at [i*AW+:AW] / [i*DW+:DW]); mem_cs/mem_addr/mem_data/mem_ok to memory.
// Build option: JT7759_ARB_PRIO_EN selects fixed priority (lowest index wins)
// instead of the default round-robin.
module jt7759_rom_arb
   import jt7759_pkg::*;
#(
   parameter int NCH = 2,
   parameter int AW  = JT7759_AW,
   parameter int DW  = JT7759_DW
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [NCH-1:0]    ch_cs,
   input  logic [NCH*AW-1:0] ch_addr,
   output logic [NCH*DW-1:0] ch_data,
   output logic [NCH-1:0]    ch_ok,
   output logic              mem_cs,
   output logic [AW-1:0]     mem_addr,
   input  logic [DW-1:0]     mem_data,
   input  logic              mem_ok
);
   localparam int GW = NCH > 1 ? $clog2(NCH) : 1;
   arb_state_t     st;
   logic [GW-1:0]  rr, g, gnt;
   logic [NCH-1:0] miss;
   logic           fill;
   assign miss = ch_cs & ~ch_ok;
   // mem_addr doubles as the latched fetch address: it holds until the next grant
   assign fill = st == ARB_WAIT && mem_ok;
   genvar i;
   generate
      for (i = 0; i < NCH; i++) begin : g_line
         jt7759_arb_line #(.AW(AW), .DW(DW)) u_line (
            .clk     (clk),
            .rstn    (rstn),
            .cs      (ch_cs[i]),
            .addr    (ch_addr[i*AW+:AW]),
            .wr      (fill && g == GW'(i)),
            .wr_addr (mem_addr),
            .wr_data (mem_data),
            .data    (ch_data[i*DW+:DW]),
            .ok      (ch_ok[i])
         );
      end
   endgenerate
   // scanning downwards lets the first miss at or after rr win
   always_comb begin
      gnt = '0;
      for (int k = NCH - 1; k >= 0; k--)
         if (miss[(int'(rr) + k) % NCH]) gnt = GW'((int'(rr) + k) % NCH);
   end
   always_ff @(posedge clk) begin
      if (!rstn) begin
         st       <= ARB_IDLE;
         mem_cs   <= 1'b0;
         mem_addr <= '0;
         g        <= '0;
      end else begin
         case (st)
            ARB_IDLE:
               if (|miss) begin
                  g        <= gnt;
                  mem_addr <= ch_addr[gnt*AW+:AW];
                  mem_cs   <= 1'b1;
                  st       <= ARB_GUARD;
               end
            // mem_ok may still be asserted for the previous address here
            ARB_GUARD: st <= ARB_WAIT;
            ARB_WAIT:
               if (mem_ok) begin
                  mem_cs <= 1'b0;
                  st     <= ARB_IDLE;
               end
            default: st <= ARB_IDLE;
         endcase
      end
   end
`ifdef JT7759_ARB_PRIO_EN
   assign rr = '0;
`else
   always_ff @(posedge clk) begin
      if (!rstn) rr <= '0;
      else if (fill) rr <= g == GW'(NCH - 1) ? '0 : g + 1'b1;
   end
`endif
endmodule

// File: tb/tb_jt7759_rom_arb.sv
// tb_jt7759_rom_arb: randomized and directed checks of jt7759_rom_arb against a cache/queue model
module tb_jt7759_rom_arb;
   localparam int NCH = 2;
   localparam int AW  = 17;
   localparam int DW  = 8;
   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic [NCH-1:0]    cs = '0;
   logic [AW-1:0]     a0 = '0, a1 = '0;
   logic [NCH*AW-1:0] ch_addr;
   logic [NCH*DW-1:0] ch_data;
   logic [NCH-1:0]    ch_ok;
   logic              mem_cs;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_data;
   logic              mem_ok = 1'b0;
   logic              use_fn = 1'b1;
   logic [DW-1:0]     mem_force = '0;
   int n = 0, bad = 0;
   // reference model: per-channel cache contents plus the fetch in flight
   logic          mv[NCH];
   logic [AW-1:0] mt[NCH];
   logic [DW-1:0] md[NCH];
   bit            busy = 0;
   int            ph = 0, gch = 0, rr = 0;
   logic          m_cs = 1'b0;
   logic [AW-1:0] m_addr = '0;

   jt7759_rom_arb #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rstn(rstn), .ch_cs(cs), .ch_addr(ch_addr), .ch_data(ch_data),
      .ch_ok(ch_ok), .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ok(mem_ok)
   );

   function automatic logic [DW-1:0] f(input logic [AW-1:0] a);
      return DW'(a * 7 + 3) ^ a[15:8];
   endfunction

   assign ch_addr  = {a1, a0};
   assign mem_data = use_fn ? f(mem_addr) : mem_force;

   always #5 clk = ~clk;

   function automatic bit hit(input int j);
      return mv[j] && mt[j] == ch_addr[j*AW+:AW];
   endfunction

   function automatic logic [NCH-1:0] m_ok();
      logic [NCH-1:0] r;
      for (int j = 0; j < NCH; j++) r[j] = cs[j] && hit(j);
      return r;
   endfunction

   function automatic logic [NCH*DW-1:0] m_data();
      logic [NCH*DW-1:0] r;
      for (int j = 0; j < NCH; j++) r[j*DW+:DW] = md[j];
      return r;
   endfunction

   task automatic upd();
      int g;
      if (!rstn) begin
         for (int j = 0; j < NCH; j++) begin mv[j] = 0; mt[j] = '0; md[j] = '0; end
         busy = 0; rr = 0; m_cs = 0; m_addr = '0;
      end else if (!busy) begin
         g = -1;
         for (int k = 0; k < NCH; k++)
            if (g < 0 && cs[(rr + k) % NCH] && !hit((rr + k) % NCH)) g = (rr + k) % NCH;
         if (g >= 0) begin
            busy = 1; ph = 0; gch = g; m_cs = 1; m_addr = ch_addr[g*AW+:AW];
         end
      end else if (ph == 0) begin
         ph = 1;
      end else if (mem_ok) begin
         mv[gch] = 1; mt[gch] = m_addr; md[gch] = use_fn ? f(m_addr) : mem_force;
         busy = 0; m_cs = 0;
`ifndef JT7759_ARB_PRIO_EN
         rr = (gch + 1) % NCH;
`endif
      end
   endtask

   task automatic tick();
      @(posedge clk);
      upd();
      #2;
   endtask

   task automatic do_reset();
      rstn = 0; cs = '0; mem_ok = 0;
      tick(); tick();
      rstn = 1;
   endtask

   task automatic test_reset();
      rstn = 0; cs = 2'b11; a0 = 17'h10; a1 = 17'h10; mem_ok = 1;
      tick(); tick();
      n++; if (mem_cs !== 1'b0) begin bad++; $display("FAIL reset mem_cs: got %b exp 0", mem_cs); end
      n++; if (ch_ok !== 2'b00) begin bad++; $display("FAIL reset ch_ok: got %b exp 00", ch_ok); end
      n++; if (ch_data !== '0) begin bad++; $display("FAIL reset ch_data: got %h exp 0000", ch_data); end
      n++; if (mem_addr !== '0) begin bad++; $display("FAIL reset mem_addr: got %h exp 0", mem_addr); end
      rstn = 1; cs = '0; mem_ok = 0;
   endtask

   task automatic test_single_miss();
      do_reset();
      use_fn = 0; mem_force = 8'h5A; cs = 2'b01; a0 = 17'h00010;
      tick();
      n++; if ({mem_cs, mem_addr} !== {1'b1, 17'h00010}) begin bad++; $display("FAIL miss request: got cs=%b addr=%h exp cs=1 addr=00010", mem_cs, mem_addr); end
      for (int c = 0; c < 4; c++) begin
         if (c == 3) mem_ok = 1;
         tick();
         n++; if ({ch_ok, ch_data, mem_cs, mem_addr} !== {m_ok(), m_data(), m_cs, m_addr}) begin bad++; $display("FAIL miss model: got ok=%b d=%h cs=%b a=%h exp ok=%b d=%h cs=%b a=%h", ch_ok, ch_data, mem_cs, mem_addr, m_ok(), m_data(), m_cs, m_addr); end
      end
      mem_ok = 0;
      n++; if ({ch_ok[0], ch_data[7:0]} !== {1'b1, 8'h5A}) begin bad++; $display("FAIL miss fill: got ok=%b d=%h exp ok=1 d=5a", ch_ok[0], ch_data[7:0]); end
      for (int c = 0; c < 3; c++) begin
         tick();
         n++; if ({mem_cs, ch_ok[0]} !== 2'b01) begin bad++; $display("FAIL hit no refetch: got cs=%b ok=%b exp cs=0 ok=1", mem_cs, ch_ok[0]); end
      end
      use_fn = 1;
   endtask

   task automatic test_stale_ok();
      int lat;
      do_reset();
      mem_ok = 1; cs = 2'b10;
      for (int k = 1; k <= 2; k++) begin
         a1 = AW'(k); lat = 0;
         for (int c = 0; c < 8; c++) begin
            tick(); lat++;
            n++; if ({ch_ok, ch_data, mem_cs, mem_addr} !== {m_ok(), m_data(), m_cs, m_addr}) begin bad++; $display("FAIL stale model: got ok=%b d=%h cs=%b a=%h exp ok=%b d=%h cs=%b a=%h", ch_ok, ch_data, mem_cs, mem_addr, m_ok(), m_data(), m_cs, m_addr); end
            if (ch_ok[1]) break;
         end
         n++; if (lat !== 3) begin bad++; $display("FAIL stale latency: got %0d exp 3", lat); end
         n++; if (ch_data[15:8] !== f(AW'(k))) begin bad++; $display("FAIL stale data: got %h exp %h", ch_data[15:8], f(AW'(k))); end
      end
      mem_ok = 0;
   endtask

   task automatic test_contention();
      logic [AW-1:0] got[$];
      logic [AW-1:0] exp[3];
      logic pcs = 0;
      do_reset();
      mem_ok = 1; a0 = 17'h100; a1 = 17'h200; cs = 2'b11;
`ifdef JT7759_ARB_PRIO_EN
      exp = '{17'h100, 17'h101, 17'h102};
`else
      exp = '{17'h100, 17'h200, 17'h101};
`endif
      for (int c = 0; c < 16; c++) begin
         tick();
         n++; if ({ch_ok, ch_data, mem_cs, mem_addr} !== {m_ok(), m_data(), m_cs, m_addr}) begin bad++; $display("FAIL contention model: got ok=%b d=%h cs=%b a=%h exp ok=%b d=%h cs=%b a=%h", ch_ok, ch_data, mem_cs, mem_addr, m_ok(), m_data(), m_cs, m_addr); end
         if (mem_cs && !pcs) got.push_back(mem_addr);
         pcs = mem_cs;
         if (ch_ok[0]) a0 = a0 + 1'b1;
      end
      for (int k = 0; k < 3; k++) begin
         n++; if (got.size() <= k || got[k] !== exp[k]) begin bad++; $display("FAIL grant order %0d: got %h exp %h", k, got.size() > k ? got[k] : 'x, exp[k]); end
      end
      mem_ok = 0;
   endtask

   task automatic test_abort();
      do_reset();
      cs = 2'b01; a0 = 17'h40;
      tick();
      cs = 2'b00;
      tick();
      mem_ok = 1;
      tick();
      mem_ok = 0;
      n++; if ({mem_cs, ch_ok} !== 3'b000) begin bad++; $display("FAIL abort no ok: got cs=%b ok=%b exp cs=0 ok=00", mem_cs, ch_ok); end
      cs = 2'b01;
      #1;
      n++; if (ch_ok !== 2'b01 || ch_data[7:0] !== f(17'h40)) begin bad++; $display("FAIL abort rehit: got ok=%b d=%h exp ok=01 d=%h", ch_ok, ch_data[7:0], f(17'h40)); end
      tick();
      n++; if ({ch_ok, ch_data, mem_cs, mem_addr} !== {m_ok(), m_data(), m_cs, m_addr}) begin bad++; $display("FAIL abort model: got ok=%b d=%h cs=%b a=%h exp ok=%b d=%h cs=%b a=%h", ch_ok, ch_data, mem_cs, mem_addr, m_ok(), m_data(), m_cs, m_addr); end
   endtask

   task automatic test_reset_mid_fetch();
      do_reset();
      cs = 2'b01; a0 = 17'h77;
      tick(); tick();
      rstn = 0;
      tick();
      rstn = 1; cs = 2'b00;
      n++; if ({mem_cs, mem_addr} !== {1'b0, 17'h0}) begin bad++; $display("FAIL midreset abort: got cs=%b a=%h exp cs=0 a=0", mem_cs, mem_addr); end
      mem_ok = 1;
      tick();
      mem_ok = 0; cs = 2'b01;
      #1;
      n++; if ({mem_cs, ch_ok, ch_data} !== '0) begin bad++; $display("FAIL midreset late ok: got cs=%b ok=%b d=%h exp all 0", mem_cs, ch_ok, ch_data); end
      cs = 2'b00;
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         cs = NCH'($urandom);
         if ($urandom_range(3) == 0) a0 = AW'($urandom_range(3));
         if ($urandom_range(3) == 0) a1 = AW'(17'h1000 + $urandom_range(3));
         mem_ok = 1'($urandom);
         rstn = $urandom_range(99) != 0;
         tick();
         n++; if ({ch_ok, ch_data, mem_cs, mem_addr} !== {m_ok(), m_data(), m_cs, m_addr}) begin bad++; $display("FAIL random model cycle %0d: got ok=%b d=%h cs=%b a=%h exp ok=%b d=%h cs=%b a=%h", c, ch_ok, ch_data, mem_cs, mem_addr, m_ok(), m_data(), m_cs, m_addr); end
      end
      rstn = 1;
   endtask

   initial begin
      for (int j = 0; j < NCH; j++) begin mv[j] = 0; mt[j] = '0; md[j] = '0; end
      test_reset();
      test_single_miss();
      test_stale_ok();
      test_contention();
      test_abort();
      test_reset_mid_fetch();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n, bad);
      $finish;
   end
endmodule
